mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/cpu_types_pkg.sv | 29 ++
 rtl/wait_timer.sv | 38 +++
 rtl/mem_responder.sv | 134 +++++++++++++
 tb/tb_mem_responder.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// ============================================================================
// Module : cpu_types_pkg
// Brief  : Shared CPU types: word type, memory-responder FSM states, bad data.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DACC  = 3'd1,
    IACC  = 3'd2,
    DRESP = 3'd3,
    IRESP = 3'd4
  } memresp_state_t;

  // Returned in place of RAM data when an access times out
  localparam word_t BADDATA = 32'hBAD1BAD1;

  function automatic word_t resp_data(input logic ready, input word_t load);
    return ready ? load : BADDATA;
  endfunction

endpackage

`default_nettype wire

// File: rtl/wait_timer.sv
// ============================================================================
// Module : wait_timer
// Brief  : Counts enabled cycles; expired marks the TIMEOUT-th enabled cycle.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module wait_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic CLK,
  input  logic nRST,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int c_CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(TIMEOUT - 1);

  logic [c_CNT_W-1:0] r_count;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (enable && !expired) begin
      r_count <= r_count + 1'b1;
    end
  end

  // Counter holds the number of enabled cycles already completed
  assign expired = enable && (r_count == c_LAST);

endmodule

`default_nettype wire

// File: rtl/mem_responder.sv
// ============================================================================
// Module : mem_responder
// Brief  : Arbitrates dcache/icache requests onto one RAM port with timeout.
//          Define MEM_STATS_EN to enable the dxfers/ixfers transfer counters.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module mem_responder
  import cpu_types_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic  CLK,
  input  logic  nRST,
  input  logic  dREN,
  input  logic  dWEN,
  input  word_t daddr,
  input  word_t dstore,
  output logic  dwait,
  output word_t dload,
  input  logic  iREN,
  input  word_t iaddr,
  output logic  iwait,
  output word_t iload,
  output logic  ramREN,
  output logic  ramWEN,
  output word_t ramaddr,
  output word_t ramstore,
  input  word_t ramload,
  input  logic  ramready,
  output logic  memerr,
  output word_t dxfers,
  output word_t ixfers
);

  memresp_state_t r_state;
  logic           w_in_acc;
  logic           w_expired;

  assign w_in_acc = (r_state == DACC) || (r_state == IACC);

  wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .CLK     (CLK),
    .nRST    (nRST),
    .clear   (!w_in_acc),
    .enable  (w_in_acc),
    .expired (w_expired)
  );

  // ramaddr/ramstore/ramWEN double as the latched request for the access
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state  <= IDLE;
      dwait    <= 1'b1;
      iwait    <= 1'b1;
      dload    <= '0;
      iload    <= '0;
      ramREN   <= 1'b0;
      ramWEN   <= 1'b0;
      ramaddr  <= '0;
      ramstore <= '0;
      memerr   <= 1'b0;
    end else begin
      dwait <= 1'b1;
      iwait <= 1'b1;
      case (r_state)
        IDLE: begin
          if (dREN || dWEN) begin
            ramaddr  <= daddr;
            ramstore <= dstore;
            ramWEN   <= dWEN;
            ramREN   <= !dWEN;
            r_state  <= DACC;
          end else if (iREN) begin
            ramaddr  <= iaddr;
            ramWEN   <= 1'b0;
            ramREN   <= 1'b1;
            r_state  <= IACC;
          end
        end
        DACC: begin
          if (ramready || w_expired) begin
            ramREN  <= 1'b0;
            ramWEN  <= 1'b0;
            dwait   <= 1'b0;
            dload   <= resp_data(ramready, ramload);
            if (!ramready) memerr <= 1'b1;
            r_state <= DRESP;
          end
        end
        IACC: begin
          if (ramready || w_expired) begin
            ramREN  <= 1'b0;
            ramWEN  <= 1'b0;
            iwait   <= 1'b0;
            iload   <= resp_data(ramready, ramload);
            if (!ramready) memerr <= 1'b1;
            r_state <= IRESP;
          end
        end
        DRESP:   r_state <= IDLE;
        IRESP:   r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef MEM_STATS_EN
  word_t r_dxfers;
  word_t r_ixfers;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_dxfers <= '0;
      r_ixfers <= '0;
    end else begin
      if (r_state == DRESP) r_dxfers <= r_dxfers + 32'd1;
      if (r_state == IRESP) r_ixfers <= r_ixfers + 32'd1;
    end
  end

  assign dxfers = r_dxfers;
  assign ixfers = r_ixfers;
`else
  assign dxfers = '0;
  assign ixfers = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_responder.sv
// ============================================================================
// Module : tb_mem_responder
// Brief  : Self-checking bench for mem_responder (directed table + random).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_mem_responder;
  import cpu_types_pkg::*;

  localparam int TO = 8;

  logic  CLK = 1'b0;
  logic  nRST;
  logic  dREN, dWEN, iREN, ramready;
  word_t daddr, dstore, iaddr, ramload;
  logic  dwait, iwait, ramREN, ramWEN, memerr;
  word_t dload, iload, ramaddr, ramstore, dxfers, ixfers;

  mem_responder #(.TIMEOUT(TO)) dut (
    .CLK(CLK), .nRST(nRST),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramready(ramready),
    .memerr(memerr), .dxfers(dxfers), .ixfers(ixfers)
  );

  always #5 CLK = ~CLK;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic        m_memerr;
  int unsigned m_dx, m_ix;

  typedef struct {
    bit    is_d;
    bit    rd;
    bit    wr;
    word_t addr;
    word_t data;
    int    lat;
    word_t rdata;
    logic  exp_we;
    word_t exp_load;
  } vec_t;

  vec_t vecs[8];

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic word_t exp_stat(input int unsigned v);
`ifdef MEM_STATS_EN
    return word_t'(v);
`else
    return (v == 0) ? 32'd0 : 32'd0;
`endif
  endfunction

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_waits"},  {dwait, iwait}, 2'b11);
    chk({tag, "_loads"},  dload | iload, 32'd0);
    chk({tag, "_strobe"}, {ramREN, ramWEN}, 2'b00);
    chk({tag, "_ramaddr"}, ramaddr, 32'd0);
    chk({tag, "_ramstore"}, ramstore, 32'd0);
    chk({tag, "_memerr"}, memerr, 1'b0);
    chk({tag, "_xfers"}, dxfers | ixfers, 32'd0);
  endtask

  // One transfer: request at cycle 0, RAM answers in the lat-th strobe cycle
  // unless lat exceeds TO, in which case the timeout path must fire.
  task automatic run_xfer(input bit is_d, input bit rd, input bit wr,
                          input word_t addr, input word_t data, input int lat,
                          input word_t rdata, input logic exp_we,
                          input word_t exp_load, input bit stray);
    bit timed;
    int n;
    timed = (lat > TO);
    n     = timed ? TO : lat;
    @(negedge CLK);
    ramready = 1'b0;
    if (is_d) begin
      dREN = rd; dWEN = wr; daddr = addr; dstore = data;
    end else begin
      iREN = 1'b1; iaddr = addr;
    end
    for (int c = 1; c <= n + 2; c++) begin
      @(negedge CLK);
      dREN = 1'b0; dWEN = 1'b0; iREN = 1'b0; ramready = 1'b0;
      daddr = $urandom; dstore = $urandom; iaddr = $urandom;
      if (c <= n) begin
        chk("acc_strobes", {ramREN, ramWEN}, {!exp_we, exp_we});
        chk("acc_ramaddr", ramaddr, addr);
        if (exp_we) chk("acc_ramstore", ramstore, data);
        chk("acc_waits", {dwait, iwait}, 2'b11);
        if (c == lat) begin
          ramready = 1'b1;
          ramload  = rdata;
        end
      end else if (c == n + 1) begin
        if (timed) m_memerr = 1'b1;
        if (is_d) m_dx++; else m_ix++;
        chk("resp_strobes", {ramREN, ramWEN}, 2'b00);
        chk("resp_waits", {dwait, iwait}, is_d ? 2'b01 : 2'b10);
        chk("resp_load", is_d ? dload : iload, exp_load);
        chk("resp_memerr", memerr, m_memerr);
        if (stray) begin
          ramready = 1'b1;
          ramload  = $urandom;
        end
      end else begin
        chk("idle_after", {ramREN, ramWEN, dwait, iwait}, 4'b0011);
        chk("dxfers", dxfers, exp_stat(m_dx));
        chk("ixfers", ixfers, exp_stat(m_ix));
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit    r_is_d, r_rd, r_wr, r_stray;
    int    r_lat;
    word_t r_addr, r_data, r_rdata;

    vecs[0] = '{1'b1, 1'b1, 1'b0, 32'h40,   32'h0,    3,      32'h12345678, 1'b0, 32'h12345678};
    vecs[1] = '{1'b1, 1'b1, 1'b1, 32'h3100, 32'hCAFE, 2,      32'h00000055, 1'b1, 32'h00000055};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 32'h1000, 32'h0,    1,      32'hA5A50001, 1'b0, 32'hA5A50001};
    vecs[3] = '{1'b1, 1'b0, 1'b1, 32'h8,    32'hDEAD, 5,      32'h0,        1'b1, 32'h0};
    vecs[4] = '{1'b0, 1'b1, 1'b0, 32'h2000, 32'h0,    TO,     32'h0BADF00D, 1'b0, 32'h0BADF00D};
    vecs[5] = '{1'b1, 1'b1, 1'b0, 32'h44,   32'h0,    TO + 1, 32'h77777777, 1'b0, 32'hBAD1BAD1};
    vecs[6] = '{1'b0, 1'b1, 1'b0, 32'h48,   32'h0,    20,     32'h66666666, 1'b0, 32'hBAD1BAD1};
    vecs[7] = '{1'b1, 1'b1, 1'b0, 32'h4C,   32'h0,    1,      32'hFFFFFFFF, 1'b0, 32'hFFFFFFFF};

    nRST = 1'b0;
    dREN = 1'b0; dWEN = 1'b0; iREN = 1'b0; ramready = 1'b0;
    daddr = '0; dstore = '0; iaddr = '0; ramload = '0;
    m_memerr = 1'b0; m_dx = 0; m_ix = 0;

    @(negedge CLK);
    check_reset_outputs("reset");
    @(negedge CLK);
    nRST = 1'b1;

    foreach (vecs[k]) begin
      run_xfer(vecs[k].is_d, vecs[k].rd, vecs[k].wr, vecs[k].addr, vecs[k].data,
               vecs[k].lat, vecs[k].rdata, vecs[k].exp_we, vecs[k].exp_load, 1'b0);
    end
    chk("memerr_sticky", memerr, 1'b1);

    // Reset in the middle of a dcache access
    @(negedge CLK);
    dREN = 1'b1; daddr = 32'h77;
    @(negedge CLK);
    dREN = 1'b0;
    chk("rst_acc_strobe", {ramREN, ramWEN}, 2'b10);
    @(negedge CLK);
    nRST = 1'b0;
    #1;
    check_reset_outputs("rst_acc");
    @(negedge CLK);
    nRST = 1'b1;
    m_memerr = 1'b0; m_dx = 0; m_ix = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge CLK);
      chk("rst_no_resp", {ramREN, ramWEN, dwait, iwait}, 4'b0011);
    end

    run_xfer(1'b1, 1'b1, 1'b0, 32'h500, 32'h0, 2, 32'h0000ABCD, 1'b0, 32'h0000ABCD, 1'b0);
    run_xfer(1'b0, 1'b1, 1'b0, 32'h504, 32'h0, 1, 32'h00001234, 1'b0, 32'h00001234, 1'b1);
    run_xfer(1'b1, 1'b0, 1'b1, 32'h508, 32'h9, 4, 32'h0,        1'b1, 32'h0,        1'b0);
    run_xfer(1'b0, 1'b1, 1'b0, 32'h50C, 32'h0, 3, 32'h00005678, 1'b0, 32'h00005678, 1'b0);
    run_xfer(1'b1, 1'b1, 1'b0, 32'h510, 32'h0, 1, 32'h00009999, 1'b0, 32'h00009999, 1'b1);
    chk("dxfers_after_3d", dxfers, exp_stat(3));
    chk("ixfers_after_2i", ixfers, exp_stat(2));
    chk("memerr_clear", memerr, 1'b0);

    for (int t = 0; t < 40; t++) begin
      r_is_d  = 1'($urandom_range(0, 1));
      r_rd    = 1'($urandom_range(0, 1));
      r_wr    = 1'($urandom_range(0, 1));
      if (!r_rd && !r_wr) r_rd = 1'b1;
      r_lat   = int'($urandom_range(1, TO + 3));
      r_addr  = $urandom;
      r_data  = $urandom;
      r_rdata = $urandom;
      r_stray = 1'($urandom_range(0, 1));
      run_xfer(r_is_d, r_rd, r_wr, r_addr, r_data, r_lat, r_rdata,
               r_is_d && r_wr, (r_lat > TO) ? BADDATA : r_rdata, r_stray);
      if ($urandom_range(0, 1) == 1) begin
        @(negedge CLK);
        chk("gap_idle", {ramREN, ramWEN, dwait, iwait}, 4'b0011);
        ramready = 1'b1;
        ramload  = $urandom;
      end
    end

    // Simultaneous dcache and icache requests; icache held until serviced
    @(negedge CLK);
    ramready = 1'b0;
    dREN = 1'b1; daddr = 32'h200; iREN = 1'b1; iaddr = 32'h300;
    for (int c = 1; c <= 8; c++) begin
      @(negedge CLK);
      dREN = 1'b0; ramready = 1'b0;
      if (c >= 5) iREN = 1'b0;
      case (c)
        1, 2: begin
          chk("dual_d_strobe", {ramREN, ramWEN}, 2'b10);
          chk("dual_d_addr", ramaddr, 32'h200);
          chk("dual_iwait_hold", iwait, 1'b1);
          if (c == 2) begin ramready = 1'b1; ramload = 32'h11112222; end
        end
        3: begin
          m_dx++;
          chk("dual_d_resp", {dwait, iwait}, 2'b01);
          chk("dual_dload", dload, 32'h11112222);
        end
        4: chk("dual_idle", {ramREN, ramWEN, dwait, iwait}, 4'b0011);
        5, 6: begin
          chk("dual_i_strobe", {ramREN, ramWEN}, 2'b10);
          chk("dual_i_addr", ramaddr, 32'h300);
          if (c == 6) begin ramready = 1'b1; ramload = 32'h33334444; end
        end
        7: begin
          m_ix++;
          chk("dual_i_resp", {dwait, iwait}, 2'b10);
          chk("dual_iload", iload, 32'h33334444);
        end
        default: begin
          chk("dual_end_idle", {ramREN, ramWEN, dwait, iwait}, 4'b0011);
          chk("dual_dxfers", dxfers, exp_stat(m_dx));
          chk("dual_ixfers", ixfers, exp_stat(m_ix));
        end
      endcase
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
